vedic_seq_mul_8x8: RTL and testbench

//   Sequencer that computes an unsigned 8x8 -> 16-bit product on one shared VedicMul_4x4.

---
 rtl/vedic_mul_pkg.sv | 14 +
 rtl/VedicMul_4x4.sv | 20 ++
 rtl/vedic_seq_mul_8x8.sv | 57 +++++
 tb/tb_vedic_seq_mul_8x8.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/vedic_mul_pkg.sv
// vedic_mul_pkg: shared constants, state encoding and shift table for the sequential 8x8 Vedic multiplier
package vedic_mul_pkg;
    localparam int SUB_W = 4;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [1:0] LAST_STEP = 2'd3;
    localparam logic [3:0] SHIFT_TAB [4] = '{4'd0, 4'd4, 4'd4, 4'd8};
    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        CALC = ST_CALC,
        DONE = ST_DONE
    } state_t;
endpackage

// File: rtl/VedicMul_4x4.sv
// VedicMul_4x4: combinational 4x4 unsigned multiplier built from four urdhva-tiryagbhyam 2x2 cells
module VedicMul_4x4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);
    function automatic logic [3:0] vm2(input logic [1:0] x, input logic [1:0] y);
        // vertical x0y0, crosswise x1y0^x0y1 with its carry folded into x1y1
        return {x[1] & y[1] & x[1] & y[0] & x[0] & y[1],
                (x[1] & y[1]) ^ (x[1] & y[0] & x[0] & y[1]),
                (x[1] & y[0]) ^ (x[0] & y[1]),
                x[0] & y[0]};
    endfunction
    logic [3:0] q0, q1, q2, q3;
    assign q0 = vm2(a[1:0], b[1:0]);
    assign q1 = vm2(a[3:2], b[1:0]);
    assign q2 = vm2(a[1:0], b[3:2]);
    assign q3 = vm2(a[3:2], b[3:2]);
    assign p = {4'b0, q0} + {2'b0, q1, 2'b0} + {2'b0, q2, 2'b0} + {q3, 4'b0};
endmodule

// File: rtl/vedic_seq_mul_8x8.sv
// vedic_seq_mul_8x8: unsigned 8x8 multiply issuing four 4x4 partial products on one shared VedicMul_4x4
module vedic_seq_mul_8x8
    import vedic_mul_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] product
);
    localparam int DATA_W = 2 * SUB_W;
    state_t state, state_nx;
    logic [1:0] step;
    logic [DATA_W-1:0] a_q, b_q, pp;
    logic [2*DATA_W-1:0] acc;
    logic [SUB_W-1:0] mul_a, mul_b;
    logic accept;
    // step bit 0 picks the high nibble of a, bit 1 the high nibble of b
    assign mul_a = step[0] ? a_q[DATA_W-1:SUB_W] : a_q[SUB_W-1:0];
    assign mul_b = step[1] ? b_q[DATA_W-1:SUB_W] : b_q[SUB_W-1:0];
    VedicMul_4x4 u_mul (.a(mul_a), .b(mul_b), .p(pp));
    assign in_ready = !rst && (state == IDLE || (state == DONE && out_ready));
    assign accept = in_valid && in_ready;
    assign out_valid = state == DONE;
    assign product = acc;
    always_comb begin
        state_nx = state;
        state_nx = accept ? CALC
                 : state == CALC ? (step == LAST_STEP ? DONE : CALC)
                 : (state == DONE && out_ready) ? IDLE
                 : state;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step <= '0;
            acc <= '0;
            a_q <= '0;
            b_q <= '0;
        end else if (accept) begin
            step <= '0;
            acc <= '0;
            a_q <= a;
            b_q <= b;
        end else if (state == CALC) begin
            step <= step + 2'd1;
            acc <= acc + ({{DATA_W{1'b0}}, pp} << SHIFT_TAB[step]);
        end
    end
endmodule

// File: tb/tb_vedic_seq_mul_8x8.sv
// tb_vedic_seq_mul_8x8: vector table, handshake corner cases and randomized scoreboard run
module tb_vedic_seq_mul_8x8;
    logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
    logic [7:0] a = 0, b = 0;
    logic in_ready, out_valid;
    logic [15:0] product;
    int passed = 0, total = 0;
    logic [15:0] sb[$];
    bit rnd_on;
    typedef struct {logic [7:0] a; logic [7:0] b; logic [15:0] exp;} vec_t;
    vec_t vecs[6];

    always #5 clk = ~clk;

    vedic_seq_mul_8x8 dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .product(product)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // called just after a rising edge; holds in_valid until the pair is taken
    task automatic send(input logic [7:0] x, input logic [7:0] y);
        bit ok = 0;
        a = x; b = y; in_valid = 1;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 0;
        if (!ok) begin
            total++;
            $display("FAIL send_timeout: in_ready stayed 0 for a=%0d b=%0d", x, y);
        end
    endtask

    // lat counts rising edges from the accepting edge (inclusive) to out_valid
    task automatic wait_out(output int lat);
        bit seen = 0;
        lat = 1;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(negedge clk);
            seen = out_valid;
            if (!seen) begin
                @(posedge clk);
                #1;
                lat++;
            end
        end
        if (!seen) begin
            total++;
            $display("FAIL out_timeout: out_valid stayed 0, required 1");
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready) sb.push_back(16'(a) * 16'(b));
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    $display("FAIL sb_spurious: product %0d delivered, required no output", product);
                end else chk("sb_product", product, sb.pop_front());
            end
        end
    end

    initial begin
        int lat;
        bit stable, quiet;
        vecs[0] = '{8'd15, 8'd13, 16'd195};
        vecs[1] = '{8'hFF, 8'hFF, 16'd65025};
        vecs[2] = '{8'h00, 8'hA7, 16'd0};
        vecs[3] = '{8'h80, 8'h02, 16'd256};
        vecs[4] = '{8'h01, 8'h01, 16'd1};
        vecs[5] = '{8'h10, 8'h10, 16'd256};
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready", in_ready, 0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_product", product, 0);
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("release_in_ready", in_ready, 1);
        @(posedge clk); #1;
        out_ready = 1;
        foreach (vecs[i]) begin
            send(vecs[i].a, vecs[i].b);
            wait_out(lat);
            chk($sformatf("vec%0d_latency", i), lat, 5);
            chk($sformatf("vec%0d_product", i), product, vecs[i].exp);
            @(posedge clk); #1;
        end
        out_ready = 0;
        send(8'd200, 8'd100);
        wait_out(lat);
        stable = 1;
        repeat (7) begin
            @(negedge clk);
            stable &= out_valid && product == 16'd20000 && !in_ready;
        end
        chk("backpressure_hold", stable, 1);
        @(posedge clk); #1;
        out_ready = 1; in_valid = 1; a = 8'd3; b = 8'd7;
        @(negedge clk);
        chk("b2b_in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 0;
        wait_out(lat);
        chk("b2b_latency", lat, 5);
        chk("b2b_product", product, 21);
        @(posedge clk); #1;
        send(8'd9, 8'd11);
        a = 8'hFF; b = 8'hFF; in_valid = 1;
        @(negedge clk);
        chk("busy_in_ready", in_ready, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_valid = 0;
        wait_out(lat);
        chk("busy_product", product, 99);
        @(posedge clk); #1;
        quiet = 1;
        repeat (10) begin
            @(negedge clk);
            quiet &= !out_valid;
        end
        chk("busy_no_second_txn", quiet, 1);
        @(posedge clk); #1;
        send(8'd77, 8'd88);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1;
        #1;
        chk("abort_in_ready", in_ready, 0);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_product", product, 0);
        sb.delete();
        @(posedge clk); #1;
        rst = 0;
        quiet = 1;
        repeat (10) begin
            @(negedge clk);
            quiet &= !out_valid;
        end
        chk("abort_no_output", quiet, 1);
        chk("abort_idle_ready", in_ready, 1);
        @(posedge clk); #1;
        rnd_on = 1;
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk); #1;
                    end
                    send(8'($urandom), 8'($urandom));
                end
                rnd_on = 0;
            end
            begin
                while (rnd_on) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1;
        repeat (20) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
